multiplier_ieee_754_apb_master: RTL

APB initiator that drives the IEEE-754 single-precision multiplier's APB slave wrapper from a simple valid/ready host port. It accepts an operand pair, issues the two-phase APB write sequence the multiplier wrapper expects (op1 posted, op2 held until `pready`), captures `prdata` as the product, and returns it to the host. It sits between the virtual platform's processor-side logic and the multiplier's APB wrapper.

---
 rtl/multiplier_ieee_754_apb_master_pkg.sv | 15 +
 rtl/multiplier_ieee_754_apb_master_apb_timeout_counter.sv | 30 +++
 rtl/multiplier_ieee_754_apb_master.sv | 131 +++++++++++++
 3 files changed

// File: rtl/multiplier_ieee_754_apb_master_pkg.sv
// Shared definitions for the APB initiator of the IEEE-754 multiplier wrapper.
package multiplier_ieee_754_apb_master_pkg;

   localparam int DEFAULT_SIZE = 32;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETUP1  = 3'd1,
      ST_ACCESS1 = 3'd2,
      ST_SETUP2  = 3'd3,
      ST_ACCESS2 = 3'd4,
      ST_DONE    = 3'd5
   } state_t;

endpackage

// File: rtl/multiplier_ieee_754_apb_master_apb_timeout_counter.sv
// Wait-cycle counter for the second APB access; flags the terminal count.
module apb_timeout_counter #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   input  logic clear,
   output logic terminal
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TERM = CW'(TIMEOUT);

   logic [CW-1:0] count;

   // Count enabled cycles; clear has priority so every transfer starts from zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CW'(1);
      end
   end

   assign terminal = (count == TERM);

endmodule

// File: rtl/multiplier_ieee_754_apb_master.sv
// Host valid/ready to APB bridge: writes op1 then op2, returns prdata as the product.
module multiplier_ieee_754_apb_master
   import multiplier_ieee_754_apb_master_pkg::*;
#(
   parameter int              SIZE    = DEFAULT_SIZE,
   parameter logic [SIZE-1:0] ADDR    = '0,
   parameter int              TIMEOUT = 255
) (
   input  logic            pclk,
   input  logic            presetn,
   input  logic [SIZE-1:0] op1,
   input  logic [SIZE-1:0] op2,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [SIZE-1:0] res,
   output logic            err,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [SIZE-1:0] paddr,
   output logic            psel,
   output logic            penable,
   output logic            pwrite,
   output logic [SIZE-1:0] pwdata,
   input  logic            pready,
   input  logic [SIZE-1:0] prdata
);

   state_t          state;
   state_t          next_state;
   logic [SIZE-1:0] op1_q;
   logic [SIZE-1:0] op2_q;
   logic [SIZE-1:0] pwdata_next;
   logic            sel_next;
   logic            cnt_enable;
   logic            timed_out;

   // The counter runs through SETUP2 so it already reads 1 on the first ACCESS2 cycle.
   assign cnt_enable = (state == ST_SETUP2) || (state == ST_ACCESS2);

   apb_timeout_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk      (pclk),
      .rst_n    (presetn),
      .enable   (cnt_enable),
      .clear    (!cnt_enable),
      .terminal (timed_out)
   );

   // State register.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode plus the bus values the next state will present.
   always_comb begin
      next_state  = state;
      pwdata_next = '0;
      case (state)
         ST_IDLE:    if (in_valid) next_state = ST_SETUP1;
         ST_SETUP1:  next_state = ST_ACCESS1;
         ST_ACCESS1: next_state = ST_SETUP2;
         ST_SETUP2:  next_state = ST_ACCESS2;
         ST_ACCESS2: if (pready || timed_out) next_state = ST_DONE;
         ST_DONE:    if (res_ready) next_state = ST_IDLE;
         default:    next_state = ST_IDLE;
      endcase
      case (next_state)
         ST_SETUP1:  pwdata_next = op1;   // only reachable from IDLE, operands arrive this edge
         ST_ACCESS1: pwdata_next = op1_q;
         ST_SETUP2,
         ST_ACCESS2: pwdata_next = op2_q;
         default:    pwdata_next = '0;
      endcase
      sel_next = (next_state == ST_SETUP1) || (next_state == ST_ACCESS1) ||
                 (next_state == ST_SETUP2) || (next_state == ST_ACCESS2);
   end

   // Operand capture on accept.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         op1_q <= '0;
         op2_q <= '0;
      end else if (state == ST_IDLE && in_valid) begin
         op1_q <= op1;
         op2_q <= op2;
      end
   end

   // Registered Moore outputs, decoded from the state being entered.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         in_ready  <= 1'b0;
         psel      <= 1'b0;
         penable   <= 1'b0;
         pwrite    <= 1'b0;
         paddr     <= '0;
         pwdata    <= '0;
         res_valid <= 1'b0;
      end else begin
         in_ready  <= (next_state == ST_IDLE);
         psel      <= sel_next;
         pwrite    <= sel_next;
         penable   <= (next_state == ST_ACCESS1) || (next_state == ST_ACCESS2);
         paddr     <= sel_next ? ADDR : '0;
         pwdata    <= pwdata_next;
         res_valid <= (next_state == ST_DONE);
      end
   end

   // Result capture; pready wins over a coincident timeout.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         res <= '0;
         err <= 1'b0;
      end else if (state == ST_ACCESS2) begin
         if (pready) begin
            res <= prdata;
            err <= 1'b0;
         end else if (timed_out) begin
            res <= '0;
            err <= 1'b1;
         end
      end
   end

endmodule
